// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a small receive FIFO.
//   clk          core clock, rising edge
//   RESET        asynchronous active-high reset
//   i_rxd        serial line, asynchronous, idle high
//   i_rd         pop strobe for the FIFO head
//   i_clr_err    clears the sticky error flags
//   o_data       FIFO head byte, 0 when empty
//   o_valid      FIFO non-empty
//   o_level      FIFO occupancy
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte dropped on a full FIFO
module uart_receiver #(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          i_rxd,
  input  logic                          i_rd,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
  output logic                          o_overrun
);
  localparam int CPB  = clk_freq_hz / baud_rate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  generate
    if (CPB < 4) begin : g_cpb_chk
      $error("uart_receiver: clk_freq_hz/baud_rate must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_receiver: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {BREAK, IDLE, START, DATA, STOP} state_t;

  // Two-flop synchroniser; reset low so the FSM must see the line high first.
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= i_rxd;
      rx_s <= rx_m;
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          push;
  logic [7:0]    push_data;
  logic          frame_evt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= BREAK;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_evt <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_evt <= 1'b0;
      case (state)
        BREAK: if (rx_s) state <= IDLE;
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF_LAST) begin
          // Mid start bit: a high line here was a glitch, drop it silently.
          cnt <= '0;
          if (rx_s) state <= IDLE;
          else begin
            state <= DATA;
            idx   <= '0;
          end
        end else cnt <= cnt + CW'(1);
        DATA: if (cnt == CPB_LAST) begin
          cnt        <= '0;
          shreg[idx] <= rx_s;
          if (idx == 3'd7) state <= STOP;
          else idx <= idx + 3'd1;
        end else cnt <= cnt + CW'(1);
        STOP: if (cnt == CPB_LAST) begin
          cnt <= '0;
          if (rx_s) begin
            push      <= 1'b1;
            push_data <= shreg;
            state     <= IDLE;
          end else begin
            // Low stop bit: flag once, then park until the line returns high.
            frame_evt <= 1'b1;
            state     <= BREAK;
          end
        end else cnt <= cnt + CW'(1);
        default: state <= BREAK;
      endcase
    end
  end

  // Receive FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, do_pop, do_push, ovf_evt;

  assign o_level = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (o_level == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = i_rd && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;
  assign o_valid = !empty;
  assign o_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Sticky flags: a new event outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (frame_evt)      o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
      if (ovf_evt)        o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of uart_receiver at CPB=100, HALF=50.
module tb_uart_receiver;
  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       i_rxd = 1'b1;
  logic       i_rd = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_level;
  logic       o_frame_err;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;
  int lat = 954;

  uart_receiver #(.clk_freq_hz(100000000), .baud_rate(1000000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RESET(RESET), .i_rxd(i_rxd), .i_rd(i_rd), .i_clr_err(i_clr_err),
    .o_data(o_data), .o_valid(o_valid), .o_level(o_level),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    i_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rxd = d[i];
      tick(CPB);
    end
    i_rxd = stop_bit;
    tick(CPB);
  endtask

  task automatic pop();
    i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({o_valid, o_level, o_data, o_frame_err, o_overrun} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%0d d=%h fe=%b ov=%b exp all 0",
               o_valid, o_level, o_data, o_frame_err, o_overrun);
    end
    RESET = 1'b0;
    tick(10);
  endtask

  task automatic test_basic();
    int cnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!o_valid && cnt < 2000) begin
          tick(1);
          cnt++;
        end
      end
    join
    lat = cnt;
    checks++;
    if (cnt < 951 || cnt > 955) begin
      errors++;
      $display("FAIL t1_latency got %0d exp 953+/-2", cnt);
    end
    checks++;
    if (o_data !== 8'hA5 || o_level !== 3'd1) begin
      errors++;
      $display("FAIL t1_data got %h/%0d exp a5/1", o_data, o_level);
    end
    pop();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      errors++;
      $display("FAIL t1_pop got v=%b d=%h exp 0/00", o_valid, o_data);
    end
  endtask

  task automatic test_glitch();
    i_rxd = 1'b0;
    tick(30);
    i_rxd = 1'b1;
    tick(200);
    checks++;
    if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL t2_glitch got v=%b fe=%b exp 0/0", o_valid, o_frame_err);
    end
    send_frame(8'h5A, 1'b1);
    tick(5);
    checks++;
    if (o_data !== 8'h5A || o_level !== 3'd1) begin
      errors++;
      $display("FAIL t2_after got %h/%0d exp 5a/1", o_data, o_level);
    end
    pop();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    tick(200);
    i_rxd = 1'b1;
    tick(10);
    checks++;
    if (o_frame_err !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_ferr got fe=%b v=%b exp 1/0", o_frame_err, o_valid);
    end
    send_frame(8'h11, 1'b1);
    tick(5);
    checks++;
    if (o_data !== 8'h11 || o_level !== 3'd1 || o_frame_err !== 1'b1) begin
      errors++;
      $display("FAIL t3_next got %h/%0d fe=%b exp 11/1/1", o_data, o_level, o_frame_err);
    end
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    checks++;
    if (o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL t3_clr got %b exp 0", o_frame_err);
    end
    pop();
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(5);
    checks++;
    if (o_level !== 3'd4 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL t4_full got l=%0d ov=%b exp 4/1", o_level, o_overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      checks++;
      if (o_data !== exp || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL t4_pop%0d got %h v=%b exp %h/1", i, o_data, o_valid, exp);
      end
      pop();
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL t4_empty got v=%b exp 0", o_valid);
    end
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL t4_clr got %b exp 0", o_overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h99;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    tick(5);
    checks++;
    if (o_level !== 3'd4) begin
      errors++;
      $display("FAIL t5_fill got %0d exp 4", o_level);
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        // Hold the pop for exactly the cycle whose closing edge writes the byte.
        tick(lat - 1);
        i_rd = 1'b1;
        checks++;
        if (o_data !== 8'h10 || o_level !== 3'd4) begin
          errors++;
          $display("FAIL t5_pre got %h/%0d exp 10/4", o_data, o_level);
        end
        tick(1);
        i_rd = 1'b0;
        checks++;
        if (o_level !== 3'd4 || o_overrun !== 1'b0) begin
          errors++;
          $display("FAIL t5_same got l=%0d ov=%b exp 4/0", o_level, o_overrun);
        end
      end
    join
    tick(5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_data !== exp_q[i]) begin
        errors++;
        $display("FAIL t5_pop%0d got %h exp %h", i, o_data, exp_q[i]);
      end
      pop();
    end
    checks++;
    if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL t5_end got v=%b ov=%b exp 0/0", o_valid, o_overrun);
    end
  endtask

  task automatic test_mid_reset();
    send_frame(8'h42, 1'b1);
    tick(5);
    // Start a frame and reset during bit 3 while the line is low.
    i_rxd = 1'b0;
    tick(CPB * 4 + 20);
    RESET = 1'b1;
    tick(2);
    checks++;
    if ({o_valid, o_level, o_data, o_frame_err, o_overrun} !== 14'd0) begin
      errors++;
      $display("FAIL t6_reset got v=%b l=%0d d=%h fe=%b ov=%b exp all 0",
               o_valid, o_level, o_data, o_frame_err, o_overrun);
    end
    RESET = 1'b0;
    tick(500);
    checks++;
    if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL t6_low got v=%b fe=%b exp 0/0", o_valid, o_frame_err);
    end
    i_rxd = 1'b1;
    tick(10);
    send_frame(8'h7E, 1'b1);
    tick(5);
    checks++;
    if (o_data !== 8'h7E || o_level !== 3'd1) begin
      errors++;
      $display("FAIL t6_rx got %h/%0d exp 7e/1", o_data, o_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
